smem_output_collector: RTL

Consumer end of the SMEM result-output handshake. It grants `output_permit` to the result RAM's output module and frames the 512-bit beat stream into per-read packets (header plus mem beats). It buffers beats in a FIFO, throttles the producer via `stall`, and forwards packets to the host write port with sop/eop markers. It also signals batch completion and protocol errors.

---
 rtl/smem_output_collector_pkg.sv | 31 +++
 rtl/smem_beat_fifo.sv | 54 +++++
 rtl/smem_output_collector.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/smem_output_collector_pkg.sv
// Shared definitions for the SMEM output collector: header field layout,
// read limits and the state encodings used by the collector and its framer.
package smem_output_collector_pkg;

  localparam int READ_NUM_WIDTH = 6;
  localparam int READ_MAX_MEM   = 40;

  localparam int BEAT_W  = 512;
  localparam int ENTRY_W = BEAT_W + 2;

  localparam int READ_NUM_LSB = 0;
  localparam int READ_NUM_MSB = 9;
  localparam int MEM_SIZE_LSB = 64;
  localparam int MEM_SIZE_MSB = 70;
  localparam int RET_LSB      = 128;
  localparam int RET_MSB      = 159;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_DRAIN,
    ST_DONE,
    ST_WAIT_LOW
  } state_t;

  typedef enum logic {
    FRM_EXP_HDR,
    FRM_EXP_MEM
  } framer_t;

endpackage

// File: rtl/smem_beat_fifo.sv
// First-word-fall-through beat buffer: the head entry is readable as soon as
// it is written, and the live occupancy is exported for producer throttling.
module smem_beat_fifo
  import smem_output_collector_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   head_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      occ_reg;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (occ_reg != '0);
  assign full       = (occ_reg == (AW+1)'(DEPTH));
  assign occupancy  = occ_reg;
  assign head_data  = mem[rd_ptr_reg];

  // A full FIFO rejects the push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && head_valid;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      occ_reg <= occ_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/smem_output_collector.sv
// Consumer side of the SMEM result handshake: grants the producer, frames beats
// into header+mem packets, buffers them and forwards them to the host port.
module smem_output_collector #(
  parameter int FIFO_DEPTH     = 16,
  parameter int STALL_MARGIN   = 4,
  parameter int READ_NUM_WIDTH = smem_output_collector_pkg::READ_NUM_WIDTH,
  parameter int READ_MAX_MEM   = smem_output_collector_pkg::READ_MAX_MEM
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [READ_NUM_WIDTH:0] batch_size,
  input  logic                    output_request,
  output logic                    output_permit,
  input  logic [511:0]            output_data,
  input  logic                    output_valid,
  input  logic                    output_finish,
  output logic                    stall,
  output logic [511:0]            host_data,
  output logic                    host_valid,
  input  logic                    host_ready,
  output logic                    host_sop,
  output logic                    host_eop,
  output logic                    batch_done,
  input  logic                    batch_ack,
  output logic                    error,
  output logic [15:0]             line_count
);

  import smem_output_collector_pkg::*;

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = READ_NUM_WIDTH + 1;

  state_t             state_reg, state_next;
  framer_t            frm_reg, frm_next;
  logic [6:0]         beats_left_reg, beats_left_next;
  logic [CNT_W-1:0]   rd_cnt_reg, rd_cnt_next;
  logic               stall_reg;
  logic               error_reg;
  logic [15:0]        line_count_reg;

  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_valid;
  logic               fifo_full;
  logic [OCC_W-1:0]   fifo_occ;

  logic               beat_in, is_hdr, beat_sop, beat_eop;
  logic               host_fire, start_batch, finish_in, err_set;
  logic [9:0]         hdr_read_num;
  logic [6:0]         hdr_mem_size;
  logic [6:0]         hdr_beats;

  assign hdr_read_num = output_data[READ_NUM_MSB:READ_NUM_LSB];
  assign hdr_mem_size = output_data[MEM_SIZE_MSB:MEM_SIZE_LSB];
  // Two mem entries per beat, so a read needs ceil(mem_size/2) beats.
  assign hdr_beats    = {1'b0, hdr_mem_size[6:1]} + {6'd0, hdr_mem_size[0]};

  assign beat_in     = output_valid && (state_reg == ST_GRANT);
  assign is_hdr      = (frm_reg == FRM_EXP_HDR);
  assign beat_sop    = is_hdr;
  assign beat_eop    = is_hdr ? (hdr_mem_size == '0) : (beats_left_reg == 7'd1);
  assign host_fire   = fifo_valid && host_ready;
  assign start_batch = (state_reg == ST_IDLE) && output_request;
  assign finish_in   = (state_reg == ST_GRANT) && output_finish;

  smem_beat_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (beat_in),
    .push_data  ({beat_sop, beat_eop, output_data}),
    .pop        (host_fire),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .full       (fifo_full),
    .occupancy  (fifo_occ)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:     if (output_request) state_next = ST_GRANT;
      ST_GRANT:    if (output_finish)  state_next = ST_DRAIN;
      ST_DRAIN:    if (!fifo_valid)    state_next = ST_DONE;
      ST_DONE:     if (batch_ack)      state_next = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!output_request) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    output_permit = 1'b0;
    batch_done    = 1'b0;
    if (state_reg == ST_GRANT) output_permit = 1'b1;
    if (state_reg == ST_DONE)  batch_done    = 1'b1;
  end

  always_comb begin
    frm_next        = frm_reg;
    beats_left_next = beats_left_reg;
    rd_cnt_next     = rd_cnt_reg;
    if (start_batch) begin
      frm_next        = FRM_EXP_HDR;
      beats_left_next = '0;
      rd_cnt_next     = '0;
    end else if (beat_in) begin
      if (is_hdr) begin
        rd_cnt_next     = rd_cnt_reg + 1'b1;
        beats_left_next = hdr_beats;
        if (hdr_mem_size != '0) frm_next = FRM_EXP_MEM;
      end else begin
        beats_left_next = beats_left_reg - 1'b1;
        if (beats_left_reg == 7'd1) frm_next = FRM_EXP_HDR;
      end
    end
  end

  // Finish is judged against post-beat framer state so a final beat may ride along.
  assign err_set = (output_valid && (state_reg != ST_GRANT))
                || (beat_in && fifo_full)
                || (beat_in && is_hdr && (hdr_read_num != 10'(rd_cnt_reg)))
                || (beat_in && is_hdr && (hdr_mem_size > 7'(READ_MAX_MEM)))
                || (finish_in && ((frm_next != FRM_EXP_HDR) || (rd_cnt_next != batch_size)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frm_reg        <= FRM_EXP_HDR;
      beats_left_reg <= '0;
      rd_cnt_reg     <= '0;
      stall_reg      <= 1'b0;
      error_reg      <= 1'b0;
      line_count_reg <= '0;
    end else begin
      frm_reg        <= frm_next;
      beats_left_reg <= beats_left_next;
      rd_cnt_reg     <= rd_cnt_next;
      stall_reg      <= (state_next == ST_GRANT) &&
                        (fifo_occ >= OCC_W'(FIFO_DEPTH - STALL_MARGIN));
      if (err_set) error_reg <= 1'b1;
      if ((state_reg == ST_WAIT_LOW) && !output_request)
        line_count_reg <= '0;
      else if (host_fire && (line_count_reg != 16'hFFFF))
        line_count_reg <= line_count_reg + 16'd1;
    end
  end

  assign stall      = stall_reg;
  assign error      = error_reg;
  assign line_count = line_count_reg;
  assign host_valid = fifo_valid;
  assign host_data  = fifo_valid ? fifo_head[511:0] : '0;
  assign host_sop   = fifo_valid && fifo_head[513];
  assign host_eop   = fifo_valid && fifo_head[512];

endmodule
